// File: rtl/definitions_pkg.sv
// definitions_pkg: shared types and constants for the signed sequential divider
package definitions_pkg;
    typedef logic signed [7:0]  int8_t;
    typedef logic signed [15:0] int16_t;
    typedef logic [3:0]         cnt_t;
    typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, SIGN_FIX} div_state_e;
    localparam int DIV_ITER = 16;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division iteration on unsigned magnitudes
module div_restore_step (
    input  logic [7:0] i_rem,
    input  logic       i_bit,
    input  logic [8:0] i_dvsr,
    output logic [7:0] o_rem,
    output logic       o_q
);
    logic [8:0] shifted;
    logic [9:0] diff;
    assign shifted = {i_rem, i_bit};
    assign diff = {1'b0, shifted} - {1'b0, i_dvsr};
    assign o_q = ~diff[9];
    // remainder stays below the divisor magnitude (<=128), so 8 bits always suffice
    assign o_rem = 8'(o_q ? diff[8:0] : shifted);
endmodule

// File: rtl/signed_seq_divider.sv
// signed_seq_divider: int16 / int8 signed restoring divider, one quotient bit per cycle
module signed_seq_divider
    import definitions_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  int16_t     i_dividend,
    input  int8_t      i_divisor,
    output int16_t     o_quotient,
    output int8_t      o_remainder,
    output logic       ready,
    output logic       o_div_by_zero,
    output logic       o_overflow,
    output div_state_e o_Edo_Act
);
    div_state_e  state_q, state_d;
    int16_t      dividend_q, dividend_d;
    int8_t       divisor_q, divisor_d;
    logic [15:0] work_q, work_d;
    logic [8:0]  dvsr_q, dvsr_d;
    logic [7:0]  rem_q, rem_d;
    cnt_t        cnt_q, cnt_d;
    logic        q_sign_q, q_sign_d, d_sign_q, d_sign_d, ovf_q, ovf_d;
    int16_t      quo_q, quo_d;
    int8_t       rem_out_q, rem_out_d;
    logic        dbz_q, dbz_d, ovf_out_q, ovf_out_d;
    logic [7:0]  step_rem;
    logic        step_bit;
    logic [8:0]  divisor_ext;

    assign divisor_ext = {divisor_q[7], divisor_q};

    div_restore_step u_step (
        .i_rem  (rem_q),
        .i_bit  (work_q[15]),
        .i_dvsr (dvsr_q),
        .o_rem  (step_rem),
        .o_q    (step_bit)
    );

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        work_d     = work_q;
        dvsr_d     = dvsr_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        q_sign_d   = q_sign_q;
        d_sign_d   = d_sign_q;
        ovf_d      = ovf_q;
        quo_d      = quo_q;
        rem_out_d  = rem_out_q;
        dbz_d      = dbz_q;
        ovf_out_d  = ovf_out_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    dividend_d = i_dividend;
                    divisor_d  = i_divisor;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // work register holds the dividend magnitude and collects quotient bits from the LSB
                work_d   = dividend_q[15] ? 16'(-dividend_q) : dividend_q;
                dvsr_d   = divisor_ext[8] ? -divisor_ext : divisor_ext;
                rem_d    = '0;
                cnt_d    = '0;
                q_sign_d = dividend_q[15] ^ divisor_q[7];
                d_sign_d = dividend_q[15];
                ovf_d    = (dividend_q == 16'h8000) && (divisor_q == 8'hFF);
                if (divisor_q == '0) begin
                    state_d   = IDLE;
                    quo_d     = '0;
                    rem_out_d = '0;
                    dbz_d     = 1'b1;
                    ovf_out_d = 1'b0;
                end else begin
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                work_d = {work_q[14:0], step_bit};
                rem_d  = step_rem;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == cnt_t'(DIV_ITER - 1)) state_d = SIGN_FIX;
            end
            SIGN_FIX: begin
                quo_d     = q_sign_q ? -work_q : work_q;
                rem_out_d = d_sign_q ? -rem_q : rem_q;
                dbz_d     = 1'b0;
                ovf_out_d = ovf_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            work_q     <= '0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            q_sign_q   <= 1'b0;
            d_sign_q   <= 1'b0;
            ovf_q      <= 1'b0;
            quo_q      <= '0;
            rem_out_q  <= '0;
            dbz_q      <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            work_q     <= work_d;
            dvsr_q     <= dvsr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            q_sign_q   <= q_sign_d;
            d_sign_q   <= d_sign_d;
            ovf_q      <= ovf_d;
            quo_q      <= quo_d;
            rem_out_q  <= rem_out_d;
            dbz_q      <= dbz_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    assign ready         = (state_q == IDLE);
    assign o_quotient    = quo_q;
    assign o_remainder   = rem_out_q;
    assign o_div_by_zero = dbz_q;
    assign o_overflow    = ovf_out_q;
    assign o_Edo_Act     = state_q;
endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider: scoreboard bench for the signed sequential divider
module tb_signed_seq_divider;
    import definitions_pkg::*;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          done_cyc;
        string       name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic signed [15:0] i_dividend = '0;
    logic signed [7:0]  i_divisor = '0;
    logic signed [15:0] o_quotient;
    logic signed [7:0]  o_remainder;
    logic              ready, o_div_by_zero, o_overflow;
    div_state_e        o_Edo_Act;

    exp_t sb[$];
    int cyc = 0;
    int total = 0;
    int passed = 0;

    signed_seq_divider dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .ready         (ready),
        .o_div_by_zero (o_div_by_zero),
        .o_overflow    (o_overflow),
        .o_Edo_Act     (o_Edo_Act)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference: C-style truncating division; ready returns 18 edges after the start edge (1 for divisor 0)
    function automatic exp_t model(input int a, input int b, input int c0, input string name);
        exp_t e;
        e.name = name;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 0) begin
            e.q = '0; e.r = '0; e.dbz = 1'b1; e.done_cyc = c0 + 1;
        end else if (a == -32768 && b == -1) begin
            e.q = 16'h8000; e.r = '0; e.ovf = 1'b1; e.done_cyc = c0 + 18;
        end else begin
            e.q = 16'(a / b); e.r = 8'(a % b); e.done_cyc = c0 + 18;
        end
        return e;
    endfunction

    task automatic issue(input int a, input int b, input string name);
        i_dividend = 16'(a);
        i_divisor  = 8'(b);
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start    = 1'b0;
        i_dividend = 16'($urandom);
        i_divisor  = 8'($urandom);
        sb.push_back(model(a, b, cyc, name));
        total++;
        if (ready !== 1'b0) $display("FAIL %s busy: ready=%b required 0", name, ready);
        else passed++;
    endtask

    task automatic collect();
        exp_t e;
        int guard = 0;
        e = sb.pop_front();
        while (!ready && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (cyc !== e.done_cyc) $display("FAIL %s latency: ready at cycle %0d required %0d", e.name, cyc, e.done_cyc);
        else passed++;
        total++;
        if (o_quotient !== e.q) $display("FAIL %s quotient: got %h required %h", e.name, o_quotient, e.q);
        else passed++;
        total++;
        if (o_remainder !== e.r) $display("FAIL %s remainder: got %h required %h", e.name, o_remainder, e.r);
        else passed++;
        total++;
        if (o_div_by_zero !== e.dbz) $display("FAIL %s div_by_zero: got %b required %b", e.name, o_div_by_zero, e.dbz);
        else passed++;
        total++;
        if (o_overflow !== e.ovf) $display("FAIL %s overflow: got %b required %b", e.name, o_overflow, e.ovf);
        else passed++;
    endtask

    task automatic check_idle_zero(input string name);
        total++;
        if (ready !== 1'b1) $display("FAIL %s ready: got %b required 1", name, ready); else passed++;
        total++;
        if (o_quotient !== 16'sd0) $display("FAIL %s quotient: got %h required 0", name, o_quotient); else passed++;
        total++;
        if (o_remainder !== 8'sd0) $display("FAIL %s remainder: got %h required 0", name, o_remainder); else passed++;
        total++;
        if (o_div_by_zero !== 1'b0) $display("FAIL %s div_by_zero: got %b required 0", name, o_div_by_zero); else passed++;
        total++;
        if (o_overflow !== 1'b0) $display("FAIL %s overflow: got %b required 0", name, o_overflow); else passed++;
        total++;
        if (o_Edo_Act !== IDLE) $display("FAIL %s state: got %0d required IDLE", name, o_Edo_Act); else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        issue(100, 7, "100/7");      collect();
        issue(-3249, -57, "-3249/-57"); collect();
        issue(-100, 7, "-100/7");    collect();
        issue(100, -7, "100/-7");    collect();
    endtask

    task automatic test_div_zero();
        issue(1234, 0, "1234/0");    collect();
        issue(7, 2, "7/2 after dbz"); collect();
    endtask

    task automatic test_boundaries();
        issue(-32768, -1, "-32768/-1"); collect();
        issue(127, -128, "127/-128");   collect();
        issue(-32768, -128, "-32768/-128"); collect();
        issue(32767, 1, "32767/1");     collect();
        issue(-1, 127, "-1/127");       collect();
    endtask

    task automatic test_reset_abort();
        i_dividend = 16'sd50;
        i_divisor  = 8'sd5;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("abort");
        issue(50, 5, "50/5 restart"); collect();
    endtask

    task automatic test_ignored_start();
        issue(90, 9, "90/9 busy start");
        repeat (4) @(posedge clk);
        #1;
        i_dividend = 16'sd20;
        i_divisor  = 8'sd3;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        collect();
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b1) $display("FAIL ignored start queued: ready=%b required 1", ready);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int c0;
        i_dividend = 16'sd10;
        i_divisor  = 8'sd3;
        i_start    = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        i_dividend = -16'sd21;
        i_divisor  = 8'sd4;
        sb.push_back(model(10, 3, c0, "held 10/3"));
        sb.push_back(model(-21, 4, c0 + 19, "held -21/4"));
        collect();
        @(posedge clk); #1;
        i_start = 1'b0;
        total++;
        if (ready !== 1'b0) $display("FAIL held restart: ready=%b required 0", ready);
        else passed++;
        collect();
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int a, b;
            a = $signed(16'($urandom));
            b = $signed(8'($urandom));
            issue(a, b, $sformatf("rnd %0d/%0d", a, b));
            collect();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_reset_abort();
        test_ignored_start();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
